// File: rtl/ctrl_fsm_param_if.sv
// Control-unit bundle: instruction/status inputs from the datapath and the
// control lines driven back to PC, data memory, register file and ALU.
interface ctrl_fsm_param_if #(
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned DATA_AW = 8,
  parameter int unsigned PC_W    = 8
);
  localparam int unsigned IR_W = 4 + REG_AW + DATA_AW;

  logic [IR_W-1:0]    IR;
  logic               Stall;
  logic               RF_Ra_zero;
  logic               PC_clr;
  logic               PC_up;
  logic               PC_ld;
  logic               IR_ld;
  logic [PC_W-1:0]    PC_val;
  logic [DATA_AW-1:0] D_addr;
  logic               D_wr;
  logic [1:0]         RF_s;
  logic [DATA_AW-1:0] Imm;
  logic               RF_W_en;
  logic [REG_AW-1:0]  RF_W_addr;
  logic [REG_AW-1:0]  RF_Ra_addr;
  logic [REG_AW-1:0]  RF_Rb_addr;
  logic [2:0]         Alu_s0;
  logic [3:0]         CurrentState;
  logic               Err;

  modport master (
    input  IR, Stall, RF_Ra_zero,
    output PC_clr, PC_up, PC_ld, IR_ld, PC_val, D_addr, D_wr, RF_s, Imm, RF_W_en,
           RF_W_addr, RF_Ra_addr, RF_Rb_addr, Alu_s0, CurrentState, Err
  );

  modport slave (
    output IR, Stall, RF_Ra_zero,
    input  PC_clr, PC_up, PC_ld, IR_ld, PC_val, D_addr, D_wr, RF_s, Imm, RF_W_en,
           RF_W_addr, RF_Ra_addr, RF_Rb_addr, Alu_s0, CurrentState, Err
  );
endinterface

// File: rtl/ctrl_fsm_param.sv
// Parametrised processor control FSM: fetch/decode/execute sequencing with
// configurable load latency, jumps, fetch stall and a sticky illegal-opcode flag.
module ctrl_fsm_param #(
  parameter int unsigned REG_AW   = 4,
  parameter int unsigned DATA_AW  = 8,
  parameter int unsigned PC_W     = 8,
  parameter int unsigned MEM_WAIT = 1
) (
  input logic              Clk,
  input logic              Reset,
  ctrl_fsm_param_if.master bus
);
  localparam int unsigned IR_W = 4 + REG_AW + DATA_AW;
  localparam int unsigned T    = IR_W - 5;
  localparam int unsigned CntW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

  if (DATA_AW < 2 * REG_AW) begin : g_chk_aw
    $error("DATA_AW must be at least 2*REG_AW");
  end
  if (PC_W > DATA_AW) begin : g_chk_pc
    $error("PC_W must not exceed DATA_AW");
  end
  if (MEM_WAIT < 1) begin : g_chk_wait
    $error("MEM_WAIT must be at least 1");
  end

  typedef enum logic [3:0] {
    StNoop   = 4'd0,
    StStore  = 4'd1,
    StLoadA  = 4'd2,
    StLoadB  = 4'd3,
    StAdd    = 4'd4,
    StSub    = 4'd5,
    StHalt   = 4'd6,
    StInit   = 4'd7,
    StFetch  = 4'd8,
    StDecode = 4'd9,
    StLdi    = 4'd10,
    StJmp    = 4'd11,
    StJz     = 4'd12
  } state_e;

  state_e            state_q, state_d;
  logic              err_q, err_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [3:0]         opcode;
  logic [REG_AW-1:0]  ra, rb, rw;
  logic [DATA_AW-1:0] hi, lo;
  logic [PC_W-1:0]    tgt;

  assign opcode = bus.IR[IR_W-1 -: 4];
  assign ra     = bus.IR[T -: REG_AW];
  assign rb     = bus.IR[T-REG_AW -: REG_AW];
  assign rw     = bus.IR[REG_AW-1:0];
  assign hi     = bus.IR[T:REG_AW];
  assign lo     = bus.IR[DATA_AW-1:0];
  assign tgt    = bus.IR[PC_W-1:0];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StInit;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = '0;
    case (state_q)
      StInit:  state_d = StFetch;
      StFetch: if (!bus.Stall) state_d = StDecode;
      StDecode: begin
        case (opcode)
          4'd0:    state_d = StNoop;
          4'd1:    state_d = StStore;
          4'd2:    state_d = StLoadA;
          4'd3:    state_d = StAdd;
          4'd4:    state_d = StSub;
          4'd5:    state_d = StHalt;
          4'd6:    state_d = StLdi;
          4'd7:    state_d = StJmp;
          4'd8:    state_d = StJz;
          default: begin
            state_d = StHalt;
            err_d   = 1'b1;
          end
        endcase
      end
      StLoadA: begin
        // Count resets to zero on exit so the next load starts fresh.
        if (cnt_q == CntW'(MEM_WAIT - 1)) begin
          state_d = StLoadB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StNoop, StStore, StLoadB, StAdd, StSub, StLdi, StJmp, StJz: state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    bus.PC_clr     = 1'b0;
    bus.PC_up      = 1'b0;
    bus.PC_ld      = 1'b0;
    bus.IR_ld      = 1'b0;
    bus.PC_val     = '0;
    bus.D_addr     = '0;
    bus.D_wr       = 1'b0;
    bus.RF_s       = 2'd0;
    bus.Imm        = '0;
    bus.RF_W_en    = 1'b0;
    bus.RF_W_addr  = '0;
    bus.RF_Ra_addr = '0;
    bus.RF_Rb_addr = '0;
    bus.Alu_s0     = 3'd0;
    // Reset masks the current state so an aborted instruction issues no writes.
    if (Reset) begin
      bus.PC_clr = 1'b1;
    end else begin
      case (state_q)
        StInit: bus.PC_clr = 1'b1;
        StFetch: begin
          bus.IR_ld = !bus.Stall;
          bus.PC_up = !bus.Stall;
        end
        StStore: begin
          bus.D_addr     = lo;
          bus.D_wr       = 1'b1;
          bus.RF_Ra_addr = ra;
        end
        StLoadA, StLoadB: begin
          bus.D_addr    = hi;
          bus.RF_s      = 2'd1;
          bus.RF_W_addr = rw;
          bus.RF_W_en   = (state_q == StLoadB);
        end
        StAdd, StSub: begin
          bus.RF_Ra_addr = ra;
          bus.RF_Rb_addr = rb;
          bus.RF_W_addr  = rw;
          bus.RF_W_en    = 1'b1;
          bus.Alu_s0     = (state_q == StAdd) ? 3'd1 : 3'd2;
        end
        StLdi: begin
          bus.RF_s      = 2'd2;
          bus.Imm       = hi;
          bus.RF_W_addr = rw;
          bus.RF_W_en   = 1'b1;
        end
        StJmp: begin
          bus.PC_ld  = 1'b1;
          bus.PC_val = tgt;
        end
        StJz: begin
          bus.RF_Ra_addr = ra;
          bus.PC_val     = tgt;
          bus.PC_ld      = bus.RF_Ra_zero;
        end
        default: ;
      endcase
    end
  end

  assign bus.CurrentState = state_q;
  assign bus.Err          = err_q;
endmodule
